// File: rtl/display_pkg.sv
// Shared types and constants for the hex display scanner.
// Holds the FSM state enum, segment bit positions and the hex segment table.
package display_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  // Segment bit positions within {g,f,e,d,c,b,a}
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-high patterns, indexed by nibble value
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] seg_lookup(
    input logic [3:0] n
  );
    return SEG_TABLE[n];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to 7-segment decoder.
// Ports: nibble (4b in), seg (7b out, active-high {g..a}).
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = seg_lookup(nibble);
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex display scanner with a blank slot between digits.
// Ports: clock, isReset (async low), value, enable, dpMask in;
// segments, decimalPoint, digitSelect, frameStart out (registered).
// Option macro: LEADING_ZERO_BLANK_EN darkens leading zero digits.
module hex_display_scanner
  import display_pkg::*;
#(
  parameter int VALUE_WIDTH      = 8,
  parameter int REFRESH_DIV      = 50000,
  parameter int ACTIVE_LOW_SEG   = 1,
  parameter int ACTIVE_LOW_DIGIT = 1
) (
  input  logic                     clock,
  input  logic                     isReset,
  input  logic [VALUE_WIDTH-1:0]   value,
  input  logic                     enable,
  input  logic [VALUE_WIDTH/4-1:0] dpMask,
  output logic [6:0]               segments,
  output logic                     decimalPoint,
  output logic [VALUE_WIDTH/4-1:0] digitSelect,
  output logic                     frameStart
);

  localparam int DIGITS = VALUE_WIDTH / 4;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W  = $clog2(REFRESH_DIV);

  localparam logic [PRE_W-1:0] PRE_LAST =
    PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(DIGITS - 1);

  localparam logic [6:0] SEG_OFF =
    (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
  localparam logic DP_OFF = (ACTIVE_LOW_SEG != 0);
  localparam logic [DIGITS-1:0] DSEL_OFF =
    {DIGITS{ACTIVE_LOW_DIGIT != 0}};

  state_e                   state_q, state_d;
  logic [PRE_W-1:0]         pre_q, pre_d;
  logic [IDX_W-1:0]         index_q, index_d;
  logic [VALUE_WIDTH-1:0]   shadow_q, shadow_d;

  logic [6:0]               seg_q, seg_d;
  logic                     dp_q, dp_d;
  logic [DIGITS-1:0]        dsel_q, dsel_d;
  logic                     fs_q, fs_d;

  logic [3:0]               nib;
  logic [6:0]               seg_raw;
  logic                     dp_bit;
  logic [DIGITS-1:0]        onehot;
  logic                     dark;

  hex_to_seg7 u_dec (
    .nibble (nib),
    .seg    (seg_raw)
  );

  // Outputs are computed from the current state and registered,
  // so each displayed cycle trails its FSM cycle by one clock.
  always_ff @(posedge clock or negedge isReset) begin
    if (!isReset) begin
      state_q  <= ST_BLANK;
      pre_q    <= '0;
      index_q  <= '0;
      shadow_q <= '0;
      seg_q    <= SEG_OFF;
      dp_q     <= DP_OFF;
      dsel_q   <= DSEL_OFF;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      index_q  <= index_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      dsel_q   <= dsel_d;
      fs_q     <= fs_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    index_d  = index_q;
    shadow_d = shadow_q;
    unique case (state_q)
      ST_BLANK: begin
        state_d = ST_DRIVE;
        // Frame boundary: latch the word for a tear-free frame
        if (index_q == '0) begin
          shadow_d = value;
        end
      end
      ST_DRIVE: begin
        if (pre_q == PRE_LAST) begin
          pre_d   = '0;
          state_d = ST_BLANK;
          if (index_q == IDX_LAST) begin
            index_d = '0;
          end else begin
            index_d = index_q + 1'b1;
          end
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  always_comb begin
    nib    = '0;
    dp_bit = 1'b0;
    onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (index_q == IDX_W'(i)) begin
        nib       = shadow_q[i*4 +: 4];
        dp_bit    = dpMask[i];
        onehot[i] = 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lz_run;

  // A digit is dark when it and every higher nibble are zero
  always_comb begin
    lz_run = 1'b1;
    dark   = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run = lz_run &&
               (shadow_q[i*4 +: 4] == 4'h0);
      if (onehot[i] && lz_run) begin
        dark = 1'b1;
      end
    end
  end
`else
  always_comb begin
    dark = 1'b0;
  end
`endif

  always_comb begin
    seg_d  = SEG_OFF;
    dp_d   = DP_OFF;
    dsel_d = DSEL_OFF;
    fs_d   = (state_q == ST_BLANK) &&
             (index_q == '0);
    if ((state_q == ST_DRIVE) && enable && !dark) begin
      seg_d  = (ACTIVE_LOW_SEG != 0) ? ~seg_raw : seg_raw;
      dp_d   = (ACTIVE_LOW_SEG != 0) ? ~dp_bit : dp_bit;
      dsel_d = onehot ^ DSEL_OFF;
    end
  end

  assign segments     = seg_q;
  assign decimalPoint = dp_q;
  assign digitSelect  = dsel_q;
  assign frameStart   = fs_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner, 2 digits, REFRESH_DIV=4.
// Expected cycles are queued up front; a monitor pops one per clock.
module tb_hex_display_scanner;

  logic       clock = 1'b0;
  logic       isReset;
  logic [7:0] value;
  logic       enable;
  logic [1:0] dpMask;
  logic [6:0] segments;
  logic       decimalPoint;
  logic [1:0] digitSelect;
  logic       frameStart;

  always #5 clock = ~clock;

  hex_display_scanner #(
    .VALUE_WIDTH      (8),
    .REFRESH_DIV      (4),
    .ACTIVE_LOW_SEG   (1),
    .ACTIVE_LOW_DIGIT (1)
  ) dut (
    .clock        (clock),
    .isReset      (isReset),
    .value        (value),
    .enable       (enable),
    .dpMask       (dpMask),
    .segments     (segments),
    .decimalPoint (decimalPoint),
    .digitSelect  (digitSelect),
    .frameStart   (frameStart)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [1:0] dsel;
    logic       fs;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total  = 0;
  int   passed = 0;
  int   cur    = 0;
  int   mon_n  = 0;

  // Active-low patterns
  localparam logic [6:0] S_OFF = 7'h7F;
  localparam logic [6:0] S_0 = 7'h40;
  localparam logic [6:0] S_3 = 7'h30;
  localparam logic [6:0] S_5 = 7'h12;
  localparam logic [6:0] S_7 = 7'h78;
  localparam logic [6:0] S_A = 7'h08;
  localparam logic [6:0] S_C = 7'h46;

  task automatic chk(input string name, input int n,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s entry %0d: got %h expected %h",
                  name, n, act, exp);
  endtask

  always @(posedge clock) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      mon_n++;
      chk("segments", mon_n, {1'b0, segments}, {1'b0, mon_e.seg});
      chk("decimalPoint", mon_n, {7'b0, decimalPoint},
          {7'b0, mon_e.dp});
      chk("digitSelect", mon_n, {6'b0, digitSelect},
          {6'b0, mon_e.dsel});
      chk("frameStart", mon_n, {7'b0, frameStart},
          {7'b0, mon_e.fs});
    end
  end

  task automatic push(input logic [6:0] s, input logic d,
                      input logic [1:0] ds, input logic f);
    exp_t e;
    e.seg = s; e.dp = d; e.dsel = ds; e.fs = f;
    q.push_back(e);
  endtask

  task automatic off(input logic f);
    push(S_OFF, 1'b1, 2'b11, f);
  endtask

  task automatic dig(input int n, input int d,
                     input logic [6:0] s, input logic dp);
    repeat (n) push(s, dp, (d == 0) ? 2'b10 : 2'b01, 1'b0);
  endtask

  task automatic frame(input logic [6:0] s0, input logic dp0,
                       input logic lit1,
                       input logic [6:0] s1, input logic dp1);
    off(1'b1);
    dig(4, 0, s0, dp0);
    off(1'b0);
    if (lit1) dig(4, 1, s1, dp1);
    else repeat (4) off(1'b0);
  endtask

  task automatic at_cycle(input int n);
    while (cur < n) begin
      @(negedge clock);
      cur++;
    end
  endtask

  logic lz;

  initial begin
`ifdef LEADING_ZERO_BLANK_EN
    lz = 1'b1;
`else
    lz = 1'b0;
`endif
    isReset = 1'b0;
    value   = 8'h3A;
    enable  = 1'b1;
    dpMask  = 2'b00;
    repeat (3) @(negedge clock);
    chk("reset_segments", 0, {1'b0, segments}, {1'b0, S_OFF});
    chk("reset_frameStart", 0, {7'b0, frameStart}, 8'h00);
    chk("reset_digitSelect", 0, {6'b0, digitSelect}, 8'h03);
    isReset = 1'b1;
    cur = 0;
    frame(S_A, 1'b1, 1'b1, S_3, 1'b1);
    frame(S_C, 1'b1, 1'b1, S_5, 1'b1);
    frame(S_7, 1'b1, !lz, S_0, 1'b1);
    frame(S_0, 1'b1, !lz, S_0, 1'b1);
    repeat (2) begin
      off(1'b1);
      repeat (9) off(1'b0);
    end
    off(1'b1);
    off(1'b0);
    dig(3, 0, S_A, 1'b0);
    off(1'b0);
    dig(4, 1, S_3, 1'b1);
    frame(S_A, 1'b0, 1'b1, S_3, 1'b1);
    off(1'b1);
    dig(3, 0, S_A, 1'b0);
    at_cycle(8);  value  = 8'h5C;
    at_cycle(15); value  = 8'h07;
    at_cycle(25); value  = 8'h00;
    at_cycle(35); value  = 8'h3A;
    at_cycle(40); enable = 1'b0;
    at_cycle(60); dpMask = 2'b01;
    at_cycle(62); enable = 1'b1;
    at_cycle(80);
    repeat (4) @(posedge clock);
    #2;
    isReset = 1'b0;
    #1;
    chk("abort_segments", 84, {1'b0, segments}, {1'b0, S_OFF});
    chk("abort_dp", 84, {7'b0, decimalPoint}, 8'h01);
    chk("abort_digitSelect", 84, {6'b0, digitSelect}, 8'h03);
    chk("abort_frameStart", 84, {7'b0, frameStart}, 8'h00);
    chk("abort_queue", 84, 8'(q.size()), 8'h00);
    repeat (3) @(negedge clock);
    isReset = 1'b1;
    cur = 0;
    frame(S_A, 1'b0, 1'b1, S_3, 1'b1);
    off(1'b1);
    at_cycle(11);
    for (int i = 0; i < 20 && q.size() > 0; i++)
      @(negedge clock);
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: %0d entries left, expected 0",
                  q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hex_display_scanner.md
HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

Interface
REQ-001 Parameter VALUE_WIDTH, default 8, width of the displayed value; SHALL be a multiple of 4; DIGITS = VALUE_WIDTH/4.
REQ-002 Parameter REFRESH_DIV, default 50000, DRIVE cycles per digit; SHALL be >= 2.
REQ-003 Parameter ACTIVE_LOW_SEG, default 1, 1 = segment and decimal-point outputs are active-low.
REQ-004 Parameter ACTIVE_LOW_DIGIT, default 1, 1 = digitSelect is active-low.
REQ-005 clock  input  1  single system clock, rising edge.
REQ-006 isReset  input  1  asynchronous, active-low reset.
REQ-007 value  input  VALUE_WIDTH  word to display; digit i shows nibble i (digit 0 = LS nibble).
REQ-008 enable  input  1  1 = display lit, 0 = display dark.
REQ-009 dpMask  input  DIGITS  bit i lights the decimal point on digit i.
REQ-010 segments  output  7  {g,f,e,d,c,b,a}, a = bit 0.
REQ-011 decimalPoint  output  1  decimal point of the currently driven digit.
REQ-012 digitSelect  output  DIGITS  one-hot digit enable.
REQ-013 frameStart  output  1  one-cycle pulse at the start of each frame.

Function
REQ-014 FSM states SHALL be BLANK and DRIVE; BLANK lasts exactly 1 cycle, then DRIVE.
REQ-015 In DRIVE, the prescaler SHALL count 0..REFRESH_DIV-1; at REFRESH_DIV-1: prescaler->0, index->index+1 (DIGITS-1 wraps to 0), state->BLANK.
REQ-016 Digit period SHALL be REFRESH_DIV+1 cycles; frame period SHALL be DIGITS*(REFRESH_DIV+1) cycles.
REQ-017 In BLANK: digitSelect, segments and decimalPoint all inactive (anti-ghosting dead time).
REQ-018 frameStart SHALL be 1 only during a BLANK cycle with index==0.
REQ-019 At the end of that cycle the shadow register SHALL capture value; DRIVE cycles display only the shadow, so the frame is tear-free.
REQ-020 Every DRIVE cycle: digitSelect = one-hot(index), segments = hex decode of shadow nibble[index], decimalPoint = dpMask[index] (sampled live); all outputs glitch-free registered.
REQ-021 Hex decode, active-high {g..a}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; bitwise-inverted when ACTIVE_LOW_SEG=1.
REQ-022 enable=0: all outputs inactive in every state; FSM, prescaler, index, shadow capture and frameStart SHALL keep running.
REQ-023 A change of enable SHALL take effect on the next cycle without resetting the scan position.
REQ-024 A change of value mid-frame SHALL NOT alter displayed digits until the next frameStart.

Reset
REQ-025 isReset low SHALL immediately set: state BLANK, index 0, prescaler 0, shadow 0, all outputs inactive, frameStart 0.
REQ-026 Assertion mid-DRIVE SHALL abort the digit; the first cycle after release SHALL be BLANK with frameStart=1.

Configuration
REQ-027 Macro LEADING_ZERO_BLANK_EN defined: in DRIVE, digit i>0 SHALL be dark (digitSelect inactive) when shadow nibbles i..DIGITS-1 are all zero; digit 0 is never blanked.
REQ-028 Without LEADING_ZERO_BLANK_EN, all digits SHALL always display, leading zeros included.

Structure
REQ-029 Package display_pkg SHALL hold the state enum, the 16-entry segment table and segment bit-position constants.
REQ-030 Sub-module hex_to_seg7 (4-bit nibble -> 7-bit active-high pattern, combinational) SHALL be instantiated once.

Verification (VALUE_WIDTH=8, REFRESH_DIV=4, active-low outputs)
REQ-031 Release reset, value=8'h3A, enable=1 -> cycle 1 BLANK with frameStart=1; cycles 2-5 digitSelect=2'b10, segments=7'h08 ("A"); cycle 6 blank; cycles 7-10 digitSelect=2'b01, segments=7'h30 ("3").
REQ-032 value changes 3A->5C during cycle 8 -> cycles 7-10 still "3"; next frame shows "C" then "5"; frameStart period = 10 cycles.
REQ-033 enable=0 for two frames -> digitSelect=2'b11 and segments=7'h7F throughout; frameStart keeps a 10-cycle period; enable=1 resumes at the current index.
REQ-034 With LEADING_ZERO_BLANK_EN: value=8'h07 -> digit 1 dark, digit 0 "7"; value=8'h00 -> digit 0 "0"; without the macro both digits lit ("0").
REQ-035 isReset low during cycle 3 of DRIVE -> outputs inactive within the same cycle; after release, cycle 1 = BLANK with frameStart=1 and scan restarts at digit 0.
REQ-036 dpMask=2'b01 -> decimalPoint=0 (active) only during digit-0 DRIVE cycles; inactive in BLANK and on digit 1.
